// File: rtl/instr_decode_stage.sv
// Registered instruction decoder with valid/ready output stage,
// pending-write scoreboard, I2C-busy stall and synchronous flush.
// Ports: i_clk, i_rst_n, i_flush; fetch side i_valid/o_ready/i_instr;
// issue side o_valid/i_ready with o_dest, o_src, o_imm, o_addr,
// o_alu_ctrl, o_rd_wen, o_i2c_ctrl, o_illegal; writeback i_wb_valid,
// i_wb_reg; i_i2c_busy; debug o_pending.
module instr_decode_stage #(
  parameter int OP_W   = 5,
  parameter int REG_W  = 4,
  parameter int IMM_W  = 8,
  parameter int ADDR_W = 8,
  localparam int INSTR_W = OP_W + 2*REG_W + IMM_W,
  localparam int NREG    = 2**REG_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [REG_W-1:0]   o_dest,
  output logic [REG_W-1:0]   o_src,
  output logic [IMM_W-1:0]   o_imm,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [2:0]         o_alu_ctrl,
  output logic               o_rd_wen,
  output logic [2:0]         o_i2c_ctrl,
  output logic               o_illegal,
  input  logic               i_wb_valid,
  input  logic [REG_W-1:0]   i_wb_reg,
  input  logic               i_i2c_busy,
  output logic [NREG-1:0]    o_pending
);

  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [REG_W-1:0]  src;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        alu;
    logic              wen;
    logic [2:0]        i2c;
    logic              ill;
  } dec_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00000);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00010);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_I2CS = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_I2CP = OP_W'(5'b01000);
  localparam logic [OP_W-1:0] OP_LOAD = OP_W'(5'b01010);
  localparam logic [OP_W-1:0] OP_SCON = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OP_SI2C = OP_W'(5'b01110);
  localparam logic [OP_W-1:0] OP_SETF = OP_W'(5'b10000);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(5'b10011);
  localparam logic [OP_W-1:0] OP_BEQF = OP_W'(5'b10101);

  logic [OP_W-1:0]  w_op;
  logic [REG_W-1:0] w_dest;
  logic [REG_W-1:0] w_src;
  logic [IMM_W-1:0] w_imm;

  assign w_op   = i_instr[INSTR_W-1 -: OP_W];
  assign w_dest = i_instr[INSTR_W-OP_W-1 -: REG_W];
  assign w_src  = i_instr[INSTR_W-OP_W-REG_W-1 -: REG_W];
  assign w_imm  = i_instr[IMM_W-1:0];

  logic [2:0] w_alu;
  logic [2:0] w_i2c;
  logic       w_wen;
  logic       w_ill;
  logic       w_load;
  logic       w_rd_src;
  logic       w_rd_dst;

  always_comb begin
    w_alu    = 3'b000;
    w_i2c    = 3'b000;
    w_wen    = 1'b0;
    w_ill    = 1'b0;
    w_load   = 1'b0;
    w_rd_src = 1'b0;
    w_rd_dst = 1'b0;
    unique case (1'b1)
      (w_op == OP_ADD): begin
        w_alu    = 3'b001;
        w_wen    = 1'b1;
        w_rd_src = 1'b1;
        w_rd_dst = 1'b1;
      end
      (w_op == OP_SUB): begin
        w_alu    = 3'b010;
        w_wen    = 1'b1;
        w_rd_src = 1'b1;
        w_rd_dst = 1'b1;
      end
      (w_op == OP_ADDI): begin
        w_alu    = 3'b001;
        w_wen    = 1'b1;
        w_rd_dst = 1'b1;
      end
      (w_op == OP_I2CS): w_i2c = 3'b001;
      (w_op == OP_I2CP): w_i2c = 3'b010;
      (w_op == OP_LOAD): begin
        w_wen  = 1'b1;
        w_load = 1'b1;
      end
      (w_op == OP_SCON): begin
        w_i2c    = 3'b011;
        w_rd_src = 1'b1;
      end
      (w_op == OP_SI2C): begin
        w_i2c    = 3'b100;
        w_rd_src = 1'b1;
      end
      (w_op == OP_SETF): w_wen = 1'b1;
      (w_op == OP_BEQ): begin
        w_alu    = 3'b011;
        w_wen    = 1'b1;
        w_rd_src = 1'b1;
        w_rd_dst = 1'b1;
      end
      (w_op == OP_BEQF): begin
        w_alu    = 3'b100;
        w_wen    = 1'b1;
        w_rd_src = 1'b1;
        w_rd_dst = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
  end

  dec_t w_dec;

  always_comb begin
    w_dec      = '0;
    w_dec.dest = w_dest;
    w_dec.src  = w_load ? '0 : w_src;
    w_dec.imm  = w_op[0] ? w_imm : '0;
    w_dec.addr = w_load ? ADDR_W'(w_imm[IMM_W-1:IMM_W/2]) : '0;
    w_dec.alu  = w_alu;
    w_dec.wen  = w_wen;
    w_dec.i2c  = w_i2c;
    w_dec.ill  = w_ill;
  end

  logic            r_valid;
  dec_t            r_out;
  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pend_nxt;
  logic            w_hazard;
  logic            w_i2c_stall;
  logic            w_accept;
  logic            w_issue;

  // Write-enabled instructions also check dest (WAW).
  assign w_hazard =
    (w_rd_src & r_pending[w_src]) |
    ((w_rd_dst | w_wen) & r_pending[w_dest]);

  assign w_i2c_stall = (|w_i2c) & i_i2c_busy;

  assign o_ready = (~r_valid | i_ready)
                 & ~w_hazard & ~w_i2c_stall & ~i_flush;

  assign w_accept = i_valid & o_ready;
  assign w_issue  = r_valid & i_ready;

  // Clear first, then set, so a same-cycle set wins.
  always_comb begin
    w_pend_nxt = r_pending;
    if (i_wb_valid)
      w_pend_nxt[i_wb_reg] = 1'b0;
    if (w_accept & w_wen)
      w_pend_nxt[w_dest] = 1'b1;
    if (i_flush)
      w_pend_nxt = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_out     <= '0;
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_out   <= w_dec;
      end else if (w_issue) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_dest     = r_out.dest;
  assign o_src      = r_out.src;
  assign o_imm      = r_out.imm;
  assign o_addr     = r_out.addr;
  assign o_alu_ctrl = r_out.alu;
  assign o_rd_wen   = r_out.wen;
  assign o_i2c_ctrl = r_out.i2c;
  assign o_illegal  = r_out.ill;
  assign o_pending  = r_pending;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: directed vectors push
// expected bundles on accept; a monitor pops and compares on issue.
module tb_instr_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [20:0] i_instr;
  logic        o_valid;
  logic        i_ready;
  logic [3:0]  o_dest;
  logic [3:0]  o_src;
  logic [7:0]  o_imm;
  logic [7:0]  o_addr;
  logic [2:0]  o_alu_ctrl;
  logic        o_rd_wen;
  logic [2:0]  o_i2c_ctrl;
  logic        o_illegal;
  logic        i_wb_valid;
  logic [3:0]  i_wb_reg;
  logic        i_i2c_busy;
  logic [15:0] o_pending;

  instr_decode_stage dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_instr    (i_instr),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_dest     (o_dest),
    .o_src      (o_src),
    .o_imm      (o_imm),
    .o_addr     (o_addr),
    .o_alu_ctrl (o_alu_ctrl),
    .o_rd_wen   (o_rd_wen),
    .o_i2c_ctrl (o_i2c_ctrl),
    .o_illegal  (o_illegal),
    .i_wb_valid (i_wb_valid),
    .i_wb_reg   (i_wb_reg),
    .i_i2c_busy (i_i2c_busy),
    .o_pending  (o_pending)
  );

  typedef struct packed {
    logic [3:0] dest;
    logic [3:0] src;
    logic [7:0] imm;
    logic [7:0] addr;
    logic [2:0] alu;
    logic       wen;
    logic [2:0] i2c;
    logic       ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(
    input logic [3:0] d, input logic [3:0] s,
    input logic [7:0] im, input logic [7:0] ad,
    input logic [2:0] al, input logic w,
    input logic [2:0] ic, input logic il);
    exp_t e;
    e.dest = d; e.src = s; e.imm = im; e.addr = ad;
    e.alu = al; e.wen = w; e.i2c = ic; e.ill = il;
    return e;
  endfunction

  // Monitor: compares on issue; drops a held bundle killed by flush.
  always @(posedge clk) begin
    exp_t act;
    exp_t e;
    if (rst_n && o_valid) begin
      act = mk(o_dest, o_src, o_imm, o_addr,
               o_alu_ctrl, o_rd_wen, o_i2c_ctrl, o_illegal);
      if (i_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_issue", 32'(act), 32'h0);
        end else begin
          e = q.pop_front();
          chk("issue_bundle", 32'(act), 32'(e));
        end
      end else if (i_flush && q.size() != 0) begin
        e = q.pop_front();
      end
    end
  end

  // Called at a negedge; returns at the next negedge.
  task automatic try_one(input logic [20:0] ins,
                         input exp_t e, output bit acc);
    i_valid = 1'b1;
    i_instr = ins;
    #1;
    acc = o_ready && rst_n;
    if (acc) q.push_back(e);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic send(input logic [20:0] ins,
                      input exp_t e, input string nm);
    bit acc;
    int n = 0;
    do begin
      try_one(ins, e, acc);
      n++;
    end while (!acc && n < 20);
    chk(nm, 32'(acc), 32'd1);
  endtask

  task automatic wb(input logic [3:0] r);
    i_wb_valid = 1'b1;
    i_wb_reg   = r;
    @(negedge clk);
    i_wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   acc;
    exp_t e;
    rst_n      = 1'b0;
    i_flush    = 1'b0;
    i_valid    = 1'b1;
    i_instr    = 21'h01234;
    i_ready    = 1'b1;
    i_wb_valid = 1'b0;
    i_wb_reg   = 4'd0;
    i_i2c_busy = 1'b0;

    // Reset with a valid instruction presented
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_pending", 32'(o_pending), 32'd0);
    chk("rst_alu", 32'(o_alu_ctrl), 32'd0);
    rst_n = 1'b1;
    send(21'h01234, mk(4'd1, 4'd2, 8'h00, 8'h00,
         3'b001, 1'b1, 3'b000, 1'b0), "rst_accept");
    chk("rst_pend_set", 32'(o_pending), 32'h0002);
    wb(4'd1);
    chk("wb_clear1", 32'(o_pending), 32'h0000);

    // RAW: ADD r3,r1 then SUB r5,r3
    send({5'b00000, 4'd3, 4'd1, 8'h00}, mk(4'd3, 4'd1, 8'h00,
         8'h00, 3'b001, 1'b1, 3'b000, 1'b0), "raw_add");
    e = mk(4'd5, 4'd3, 8'h00, 8'h00, 3'b010, 1'b1, 3'b000, 1'b0);
    try_one({5'b00010, 4'd5, 4'd3, 8'h00}, e, acc);
    chk("raw_stall0", 32'(acc), 32'd0);
    try_one({5'b00010, 4'd5, 4'd3, 8'h00}, e, acc);
    chk("raw_stall1", 32'(acc), 32'd0);
    i_wb_valid = 1'b1;
    i_wb_reg   = 4'd3;
    try_one({5'b00010, 4'd5, 4'd3, 8'h00}, e, acc);
    chk("raw_stall_wb", 32'(acc), 32'd0);
    i_wb_valid = 1'b0;
    try_one({5'b00010, 4'd5, 4'd3, 8'h00}, e, acc);
    chk("raw_release", 32'(acc), 32'd1);
    wb(4'd5);
    chk("raw_pend_clr", 32'(o_pending), 32'h0000);

    // Backpressure on ADDI r2, 0xA5
    i_ready = 1'b0;
    send({5'b00101, 4'd2, 4'd0, 8'hA5}, mk(4'd2, 4'd0, 8'hA5,
         8'h00, 3'b001, 1'b1, 3'b000, 1'b0), "bp_addi");
    e = mk(4'd7, 4'd8, 8'h00, 8'h00, 3'b001, 1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", 32'(o_valid), 32'd1);
      chk("bp_hold_imm", 32'(o_imm), 32'hA5);
      try_one({5'b00000, 4'd7, 4'd8, 8'h00}, e, acc);
      chk("bp_blocked", 32'(acc), 32'd0);
    end
    i_ready = 1'b1;
    try_one({5'b00000, 4'd7, 4'd8, 8'h00}, e, acc);
    chk("bp_resume0", 32'(acc), 32'd1);
    try_one({5'b00010, 4'd9, 4'd10, 8'h00}, mk(4'd9, 4'd10, 8'h00,
            8'h00, 3'b010, 1'b1, 3'b000, 1'b0), acc);
    chk("bp_resume1", 32'(acc), 32'd1);
    chk("bp_pending", 32'(o_pending), 32'h0284);
    wb(4'd2);
    wb(4'd7);
    wb(4'd9);
    chk("bp_pend_clr", 32'(o_pending), 32'h0000);

    // I2C busy stall on SENDI2C
    e = mk(4'd0, 4'd0, 8'h00, 8'h00, 3'b000, 1'b0, 3'b100, 1'b0);
    i_i2c_busy = 1'b1;
    try_one({5'b01110, 4'd0, 4'd0, 8'h00}, e, acc);
    chk("i2c_stall", 32'(acc), 32'd0);
    i_i2c_busy = 1'b0;
    try_one({5'b01110, 4'd0, 4'd0, 8'h00}, e, acc);
    chk("i2c_release", 32'(acc), 32'd1);
    chk("i2c_ctrl", 32'(o_i2c_ctrl), 32'b100);
    chk("i2c_no_pend", 32'(o_pending), 32'h0000);

    // LOAD r4 <- [0x9C upper nibble]
    send({5'b01010, 4'd4, 4'd7, 8'h9C}, mk(4'd4, 4'd0, 8'h00,
         8'h09, 3'b000, 1'b1, 3'b000, 1'b0), "load_accept");
    chk("load_pend4", 32'(o_pending), 32'h0010);
    wb(4'd4);

    // Illegal opcode
    send({5'b11111, 4'd1, 4'd2, 8'h00}, mk(4'd1, 4'd2, 8'h00,
         8'h00, 3'b000, 1'b0, 3'b000, 1'b1), "illegal_accept");
    chk("illegal_no_pend", 32'(o_pending), 32'h0000);

    // Same-cycle set and writeback of r6
    i_wb_valid = 1'b1;
    i_wb_reg   = 4'd6;
    try_one({5'b00000, 4'd6, 4'd0, 8'h00}, mk(4'd6, 4'd0, 8'h00,
            8'h00, 3'b001, 1'b1, 3'b000, 1'b0), acc);
    i_wb_valid = 1'b0;
    chk("setclr_acc", 32'(acc), 32'd1);
    chk("setclr_pend", 32'(o_pending), 32'h0040);
    wb(4'd6);
    chk("setclr_clr", 32'(o_pending), 32'h0000);

    // Flush while holding ADDI r11
    i_ready = 1'b0;
    send({5'b00101, 4'd11, 4'd0, 8'h3C}, mk(4'd11, 4'd0, 8'h3C,
         8'h00, 3'b001, 1'b1, 3'b000, 1'b0), "flush_addi");
    chk("flush_pre_pend", 32'(o_pending), 32'h0800);
    i_flush = 1'b1;
    #1;
    chk("flush_ready", 32'(o_ready), 32'd0);
    @(negedge clk);
    i_flush = 1'b0;
    chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_pend", 32'(o_pending), 32'h0000);
    i_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered, parametrised successor to the combinational decoder of the OLED/I2C sequencer core. Sits between instruction fetch and the ALU/register-file/I2C-controller stage.
- Adds a valid/ready handshake with a one-entry output register.
- Adds a pending-write scoreboard that stalls read-after-write and write-after-write hazards.
- Adds I2C-busy stalling, illegal-opcode flagging and a synchronous flush.

Parameters:
- OP_W, 5, opcode width.
- REG_W, 4, register/flag selector width; NREG = 2**REG_W.
- IMM_W, 8, immediate width (even).
- ADDR_W, 8, memory address output width (>= IMM_W/2).
- INSTR_W, OP_W+2*REG_W+IMM_W (21), instruction width (derived; do not override).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous flush.
- i_valid  in  1  fetch has an instruction.
- o_ready  out  1  decoder accepts this cycle.
- i_instr  in  INSTR_W  fields: [INSTR_W-1 -: OP_W] opcode, next REG_W dest, next REG_W src, [IMM_W-1:0] imm.
- o_valid  out  1  decoded bundle valid.
- i_ready  in  1  downstream accepts bundle.
- o_dest  out  REG_W  destination selector.
- o_src  out  REG_W  source selector.
- o_imm  out  IMM_W  immediate.
- o_addr  out  ADDR_W  memory address.
- o_alu_ctrl  out  3  ALU op.
- o_rd_wen  out  1  register write enable.
- o_i2c_ctrl  out  3  I2C controller command.
- o_illegal  out  1  opcode not in table.
- i_wb_valid  in  1  writeback completes.
- i_wb_reg  in  REG_W  register written back.
- i_i2c_busy  in  1  I2C controller busy.
- o_pending  out  NREG  scoreboard bits (debug).

Behaviour:
- Reset (async, i_rst_n=0): o_valid=0; o_pending=0; all decoded outputs 0; o_illegal=0. o_ready is combinational.
- Opcode table (5-bit encodings, zero-extended if OP_W>5):
  - ADD 00000: alu 001, wen.
  - SUB 00010: alu 010, wen.
  - ADDI 00101: alu 001, wen.
  - I2CSTART 00110: i2c 001.
  - I2CSTOP 01000: i2c 010.
  - LOAD 01010: wen.
  - SENDCON 01100: i2c 011.
  - SENDI2C 01110: i2c 100.
  - SETFLAG 10000: wen.
  - BEQ 10011: alu 011, wen.
  - BEQF 10101: alu 100, wen.
  - Any other opcode: all controls 0, o_illegal=1.
- Field decode:
  - o_dest = dest field.
  - o_src = src field, except LOAD, which forces 0.
  - o_imm = imm field if opcode bit0=1, else 0.
  - o_addr = imm[IMM_W-1:IMM_W/2], zero-extended, for LOAD only; else 0.
- Hazard (combinational on i_instr):
  - Reads src: ADD, SUB, BEQ, BEQF, SENDCON, SENDI2C.
  - Reads dest: ADD, SUB, ADDI, BEQ, BEQF.
  - Stall if a read field's o_pending bit is set, or if o_rd_wen=1 and o_pending[dest]=1 (WAW).
- I2C stall: any i2c_ctrl!=0 instruction stalls while i_i2c_busy=1.
- o_ready = (!o_valid | i_ready) & !hazard & !i2c_stall & !i_flush.
- Accept = i_valid & o_ready.
  - Output register loads the decoded bundle; o_valid=1 next cycle (latency 1).
  - If o_rd_wen, set pending[dest].
- Issue = o_valid & i_ready: o_valid clears unless accept occurs the same cycle. Back-to-back throughput is 1 per cycle.
- Hold: while o_valid=1 and i_ready=0, all outputs are held stable.
- Clear: i_wb_valid clears pending[i_wb_reg].
  - Same-cycle set and clear of the same register: set wins.
  - Clear of an unset bit: no effect.
- Flush: i_flush=1 at an edge sets o_valid=0 and pending=0 and accepts nothing. Flush overrides accept and set.
- Illegal opcodes are accepted and issued like a NOP with o_illegal=1. No scoreboard effect.
- Reset mid-stall clears everything. Fetch must re-present the instruction.

Test Plan:
- Reset: hold i_rst_n=0 with i_valid=1, instr 21'h0_12_34 -> o_valid=0, o_pending=0. First edge after release: o_valid=1, o_alu_ctrl=001, o_dest=1, o_src=2, o_rd_wen=1, o_pending=16'h0002.
- RAW: ADD r3,r1 accepted, then SUB r5,r3 (i_ready=1, no wb) -> o_ready=0. Pulse i_wb_valid with i_wb_reg=3 -> SUB accepted next edge.
- Backpressure: i_ready=0 for 3 cycles after ADDI r2 imm 8'hA5 -> o_imm=A5 held. Next instr blocked. Resume: one issue per cycle.
- I2C stall: SENDI2C with i_i2c_busy=1 -> o_ready=0. Busy drops -> o_i2c_ctrl=100 one cycle later.
- LOAD 5'b01010 dest 4, src 7, imm 8'h9C -> o_src=0, o_addr=8'h09, o_imm=0, o_rd_wen=1, pending[4]=1.
- Edge cases:
  - Opcode 5'b11111 -> o_illegal=1, all controls 0.
  - Same-cycle accept of wen to r6 with wb r6 -> pending[6]=1.
  - i_flush during hold -> o_valid=0, o_pending=0.
